// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: registered burst arbiter that shares the vga_adapter pixel port.
// Requester 0 has fixed top priority, the rest are round-robin, and a watchdog revokes stalled grants.
module vga_plot_arbiter #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   valid,
  input  logic [N_REQ-1:0]   last,
  input  logic [9*N_REQ-1:0] x_in,
  input  logic [8*N_REQ-1:0] y_in,
  input  logic [3*N_REQ-1:0] colour_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               plot,
  output logic [8:0]         x,
  output logic [7:0]         y,
  output logic [2:0]         colour,
  output logic               busy,
  output logic [CNT_W-1:0]   burst_count,
  output logic               timeout_err
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] owner, rr_ptr, win, rr_next;
  logic [15:0] wd;
  logic [8:0] xs [N_REQ];
  logic [7:0] ys [N_REQ];
  logic [2:0] cs [N_REQ];
  logic o_req, o_valid, o_last, to_hit, done;
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign xs[i] = x_in[9*i +: 9];
    assign ys[i] = y_in[8*i +: 8];
    assign cs[i] = colour_in[3*i +: 3];
  end
  // Scan from the far end of the rotation so the requester nearest rr_ptr is assigned last and wins.
  always_comb begin
    win = '0;
    for (int k = N_REQ - 2; k >= 0; k--)
      if (req[IW'((int'(rr_ptr) - 1 + k) % (N_REQ - 1) + 1)])
        win = IW'((int'(rr_ptr) - 1 + k) % (N_REQ - 1) + 1);
    if (req[0]) win = '0;
  end
  assign o_req   = req[owner];
  assign o_valid = valid[owner];
  assign o_last  = last[owner];
  assign rr_next = (owner == IW'(N_REQ - 1)) ? IW'(1) : owner + IW'(1);
  assign to_hit  = !o_valid && (wd + 16'd1 == 16'(TIMEOUT));
  assign done    = (o_valid && o_last) || !o_req || to_hit;
  assign busy    = (state == GRANT);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= IW'(1);
      gnt         <= '0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      burst_count <= '0;
      timeout_err <= 1'b0;
      wd          <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        plot <= 1'b0;
        if (|req) begin
          state       <= GRANT;
          owner       <= win;
          gnt         <= N_REQ'(1) << win;
          burst_count <= '0;
          wd          <= '0;
        end
      end else begin
        plot <= o_valid;
        wd   <= o_valid ? 16'd0 : wd + 16'd1;
        if (o_valid) begin
          x           <= xs[owner];
          y           <= ys[owner];
          colour      <= cs[owner];
          burst_count <= burst_count + CNT_W'(~&burst_count);
        end
        if (done) begin
          state       <= IDLE;
          gnt         <= '0;
          timeout_err <= to_hit && o_req;
          if (owner != '0) rr_ptr <= rr_next;
        end
      end
    end
  end
endmodule
